ysyx_25040111_mem_arb: RTL and testbench
========================================

YSYX_25040111_MEM_ARB -- requirements
Module: ysyx_25040111_mem_arb

Interface
REQ-001 SHALL have parameters: NM, 2, number of requesters (2..8); AW, 32, address width; DW, 32, data width; LW, 8, burst-length width; RR, 1, 1 = round-robin, 0 = fixed priority (index 0 highest).
REQ-002 SHALL have ports:
  clock  in  1  clock;
  reset  in  1  reset, synchronous, active-high;
  m_valid  in  NM  request valid per requester;
  m_ready  out  NM  request-accept pulse per requester;
  m_write  in  NM  1 = write, 0 = read;
  m_addr  in  NM*AW  packed request addresses;
  m_wdata  in  NM*DW  packed write data;
  m_mask  in  NM*2  packed size code (00 = byte, 01 = half, 10/11 = word);
  m_sign  in  NM  sign-extend read;
  m_len  in  NM*LW  burst beats minus one (reads only);
  m_rbeat  out  NM  read-beat valid per requester;
  m_rdata  out  DW  shared read data;
  m_done  out  NM  transaction-complete pulse;
  m_err  out  1  error qualifier, valid with m_done;
  s_rvalid/s_rready  out/in  1  slave read handshake;
  s_raddr  out  AW;  s_rlen  out  LW;  s_burst  out  1  (s_rlen != 0);
  s_rmask  out  2;  s_rsign  out  1;
  s_rdata  in  DW;  s_rlast  in  1;
  s_wvalid/s_wready  out/in  1  slave write handshake;
  s_waddr  out  AW;  s_wdata  out  DW;  s_wmask  out  2;
  s_err  in  1  slave error, sampled on a completing handshake;
  busy  out  1  state != IDLE.

Function
REQ-003 SHALL implement states IDLE, RD and WR; only one transaction is outstanding at any time.
REQ-004 IDLE: if any m_valid bit is set, the block SHALL select one winner g, pulse m_ready[g] in that cycle, latch g and all fields of request g, and enter RD (m_write=0) or WR (m_write=1) on the next edge.
REQ-005 RR=0: the winner SHALL be the lowest set index. RR=1: the winner SHALL be the first set index at or after ptr (cyclic); ptr SHALL become (g+1) mod NM on each grant; ptr resets to 0.
REQ-006 s_rvalid SHALL be high throughout RD; s_wvalid SHALL be high throughout WR. Both SHALL be low in IDLE, giving a one-cycle grant latency.
REQ-007 The s_* request outputs SHALL come only from latched registers; changes on m_* after the grant SHALL have no effect.
REQ-008 RD: each s_rvalid & s_rready cycle is one beat and SHALL pulse m_rbeat[g] in the same cycle, with m_rdata = s_rdata.
REQ-009 RD: a beat counter SHALL count from 0; the transaction ends on beat m_len (m_len=0 is a single beat) or on s_rlast, whichever comes first.
REQ-010 On the final read beat, or on s_wready in WR, the block SHALL pulse m_done[g] in the same cycle, drive m_err = s_err, and return to IDLE on the next edge.
REQ-011 The beat counter SHALL be LW bits wide; m_len = 2^LW-1 SHALL give 2^LW beats with no early wrap.
REQ-012 When not in RD, m_rbeat and m_rdata SHALL be 0. When m_done is low, m_err SHALL be 0.
REQ-013 A new grant SHALL NOT occur in the cycle m_done pulses; the earliest next m_ready is the following cycle, so back-to-back transactions take 1 idle cycle.
REQ-014 In the cycle m_done[g] pulses, m_ready[g] SHALL be 0.
REQ-015 A requester that is not granted SHALL be held pending with m_ready low; no request is lost or reordered.

Reset
REQ-016 While reset is high, the block SHALL force: state IDLE, ptr 0, beat counter 0, all latched fields 0, and all outputs 0.
REQ-017 Reset asserted in RD or WR SHALL abort the transaction with no m_done pulse; s_rvalid and s_wvalid SHALL be low from the next edge.

Verification
REQ-018 NM=2, RR=0: m_valid=11, both reads with len 0 -> m_ready=01, then s_rvalid, then m_done[0]; one idle cycle; then m_ready=10.
REQ-019 NM=4, RR=1: all four valid continuously -> grant order 0,1,2,3,0; ptr wraps.
REQ-020 Read with len=3 and s_rready every other cycle -> exactly 4 m_rbeat pulses; m_done on the 4th beat; s_raddr stable throughout.
REQ-021 Read with len=7 and s_rlast on beat 2 -> 3 beats, then m_done; write with s_err=1 -> m_done and m_err=1 in the same cycle.
REQ-022 Write addr=0x8000_0010, data=0xDEADBEEF, mask=10, with s_wready delayed 5 cycles -> s_w* held constant; m_done on cycle 6; m_wdata changed after grant is ignored.
REQ-023 Reset pulse mid-burst (beat 2 of 8) -> all outputs 0; no m_done; a subsequent request is granted normally with ptr=0.

Source files
------------

// File: rtl/ysyx_25040111_mem_arb.sv
// Memory arbiter: NM requesters share one read port and one write port of a
// slave. One transaction is outstanding at a time. The winner is chosen by
// fixed priority or round-robin. The request is latched at grant, so the
// slave side only sees registered request fields.
`timescale 1ns/1ps
module ysyx_25040111_mem_arb #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8,
  parameter int RR = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NM-1:0]    m_valid,
  output logic [NM-1:0]    m_ready,
  input  logic [NM-1:0]    m_write,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  input  logic [NM*2-1:0]  m_mask,
  input  logic [NM-1:0]    m_sign,
  input  logic [NM*LW-1:0] m_len,
  output logic [NM-1:0]    m_rbeat,
  output logic [DW-1:0]    m_rdata,
  output logic [NM-1:0]    m_done,
  output logic             m_err,
  output logic             s_rvalid,
  input  logic             s_rready,
  output logic [AW-1:0]    s_raddr,
  output logic [LW-1:0]    s_rlen,
  output logic             s_burst,
  output logic [1:0]       s_rmask,
  output logic             s_rsign,
  input  logic [DW-1:0]    s_rdata,
  input  logic             s_rlast,
  output logic             s_wvalid,
  input  logic             s_wready,
  output logic [AW-1:0]    s_waddr,
  output logic [DW-1:0]    s_wdata,
  output logic [1:0]       s_wmask,
  input  logic             s_err,
  output logic             busy
);
  localparam int GW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d, g_q, g_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    mask_q, mask_d;
  logic          sign_q, sign_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] beat_q, beat_d;

  logic [GW-1:0] win, hi_win, lo_win;
  logic          hi_found, lo_found, any_req, grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    sel_mask;
  logic          sel_sign, sel_write;
  logic [LW-1:0] sel_len;
  logic          rd_fire, rd_last, wr_done;

  // Arbitration: lowest requester at/after ptr wins, else lowest overall.
  // With RR=0 the first search is disabled, giving plain fixed priority.
  always_comb begin
    hi_win    = '0;
    lo_win    = '0;
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    sel_sign  = 1'b0;
    sel_write = 1'b0;
    sel_len   = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (m_valid[i]) begin
        lo_found = 1'b1;
        lo_win   = GW'(i);
        if (RR != 0 && GW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_win   = GW'(i);
        end
      end
    end
    win     = hi_found ? hi_win : lo_win;
    any_req = lo_found;
    for (int i = 0; i < NM; i++) begin
      if (win == GW'(i)) begin
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*DW +: DW];
        sel_mask  = m_mask[i*2 +: 2];
        sel_sign  = m_sign[i];
        sel_write = m_write[i];
        sel_len   = m_len[i*LW +: LW];
      end
    end
  end

  assign grant   = (state_q == IDLE) && any_req;
  assign rd_fire = (state_q == RD) && s_rready;
  assign rd_last = rd_fire && ((beat_q == len_q) || s_rlast);
  assign wr_done = (state_q == WR) && s_wready;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: grant leaves IDLE, final beat / write accept returns to it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = sel_write ? WR : RD;
      RD:      if (rd_last) state_d = IDLE;
      WR:      if (wr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request fields, beat counter and round-robin pointer.
  always_comb begin
    ptr_d   = ptr_q;
    g_d     = g_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    sign_d  = sign_q;
    len_d   = len_q;
    beat_d  = beat_q;
    if (grant) begin
      g_d     = win;
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      mask_d  = sel_mask;
      sign_d  = sel_sign;
      len_d   = sel_len;
      beat_d  = '0;
      if (RR != 0) ptr_d = (win == GW'(NM - 1)) ? '0 : win + 1'b1;
    end
    if (rd_fire) beat_d = rd_last ? '0 : beat_q + 1'b1;
  end

  // Datapath registers; reset clears every latched field.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q   <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      sign_q  <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      sign_q  <= sign_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs: everything is held at zero while reset is high, including the
  // first reset cycle when the state register still holds RD/WR.
  always_comb begin
    m_ready  = '0;
    m_rbeat  = '0;
    m_rdata  = '0;
    m_done   = '0;
    m_err    = 1'b0;
    s_rvalid = 1'b0;
    s_wvalid = 1'b0;
    s_raddr  = '0;
    s_rlen   = '0;
    s_burst  = 1'b0;
    s_rmask  = '0;
    s_rsign  = 1'b0;
    s_waddr  = '0;
    s_wdata  = '0;
    s_wmask  = '0;
    busy     = 1'b0;
    if (!reset) begin
      s_raddr = addr_q;
      s_rlen  = len_q;
      s_burst = (len_q != '0);
      s_rmask = mask_q;
      s_rsign = sign_q;
      s_waddr = addr_q;
      s_wdata = wdata_q;
      s_wmask = mask_q;
      busy    = (state_q != IDLE);
      for (int i = 0; i < NM; i++) begin
        m_ready[i] = grant && (win == GW'(i));
        m_rbeat[i] = rd_fire && (g_q == GW'(i));
        m_done[i]  = (rd_last || wr_done) && (g_q == GW'(i));
      end
      if (state_q == RD) begin
        s_rvalid = 1'b1;
        m_rdata  = s_rdata;
      end
      if (state_q == WR) s_wvalid = 1'b1;
      if (rd_last || wr_done) m_err = s_err;
    end
  end
endmodule

// File: tb/tb_ysyx_25040111_mem_arb.sv
// Bench for ysyx_25040111_mem_arb: a 2-requester fixed-priority instance and
// a 4-requester round-robin instance share clock and reset. Expected
// transaction results are queued at issue and popped when m_done appears.
`timescale 1ns/1ps
module tb_ysyx_25040111_mem_arb;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // fixed-priority instance, NM=2
  logic [1:0]  f_valid, f_ready, f_write, f_sign, f_rbeat, f_done;
  logic [63:0] f_addr, f_wdata;
  logic [3:0]  f_mask;
  logic [15:0] f_len;
  logic [31:0] f_rdata, f_sraddr, f_srdata, f_swaddr, f_swdata;
  logic        f_err, f_srvalid, f_srready, f_sburst, f_srsign, f_srlast;
  logic        f_swvalid, f_swready, f_serr, f_busy;
  logic [7:0]  f_srlen;
  logic [1:0]  f_srmask, f_swmask;

  // round-robin instance, NM=4
  logic [3:0]   r_valid, r_ready, r_write, r_sign, r_rbeat, r_done;
  logic [127:0] r_addr, r_wdata;
  logic [7:0]   r_mask;
  logic [31:0]  r_len;
  logic [31:0]  r_rdata, r_sraddr, r_srdata, r_swaddr, r_swdata;
  logic         r_err, r_srvalid, r_srready, r_sburst, r_srsign, r_srlast;
  logic         r_swvalid, r_swready, r_serr, r_busy;
  logic [7:0]   r_srlen;
  logic [1:0]   r_srmask, r_swmask;

  ysyx_25040111_mem_arb #(.NM(2), .AW(32), .DW(32), .LW(8), .RR(0)) u_fp (
    .clock(clock), .reset(reset),
    .m_valid(f_valid), .m_ready(f_ready), .m_write(f_write), .m_addr(f_addr),
    .m_wdata(f_wdata), .m_mask(f_mask), .m_sign(f_sign), .m_len(f_len),
    .m_rbeat(f_rbeat), .m_rdata(f_rdata), .m_done(f_done), .m_err(f_err),
    .s_rvalid(f_srvalid), .s_rready(f_srready), .s_raddr(f_sraddr),
    .s_rlen(f_srlen), .s_burst(f_sburst), .s_rmask(f_srmask), .s_rsign(f_srsign),
    .s_rdata(f_srdata), .s_rlast(f_srlast), .s_wvalid(f_swvalid),
    .s_wready(f_swready), .s_waddr(f_swaddr), .s_wdata(f_swdata),
    .s_wmask(f_swmask), .s_err(f_serr), .busy(f_busy)
  );

  ysyx_25040111_mem_arb #(.NM(4), .AW(32), .DW(32), .LW(8), .RR(1)) u_rr (
    .clock(clock), .reset(reset),
    .m_valid(r_valid), .m_ready(r_ready), .m_write(r_write), .m_addr(r_addr),
    .m_wdata(r_wdata), .m_mask(r_mask), .m_sign(r_sign), .m_len(r_len),
    .m_rbeat(r_rbeat), .m_rdata(r_rdata), .m_done(r_done), .m_err(r_err),
    .s_rvalid(r_srvalid), .s_rready(r_srready), .s_raddr(r_sraddr),
    .s_rlen(r_srlen), .s_burst(r_sburst), .s_rmask(r_srmask), .s_rsign(r_srsign),
    .s_rdata(r_srdata), .s_rlast(r_srlast), .s_wvalid(r_swvalid),
    .s_wready(r_swready), .s_waddr(r_swaddr), .s_wdata(r_swdata),
    .s_wmask(r_swmask), .s_err(r_serr), .busy(r_busy)
  );

  typedef struct {
    int g;
    bit err;
    int beats;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // Present a request on requester gi of the RR instance, wait for its grant,
  // then drop it and scramble its fields so late changes would be visible.
  task automatic issue(input logic [1:0] gi, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] mask, input bit sgn,
                       input logic [7:0] len);
    logic [3:0] oh;
    bit granted;
    oh = 4'b0001 << gi;
    r_valid[gi] = 1'b1;
    r_write[gi] = wr;
    r_sign[gi]  = sgn;
    r_addr[{gi, 5'b0} +: 32]  = addr;
    r_wdata[{gi, 5'b0} +: 32] = data;
    r_mask[{gi, 1'b0} +: 2]   = mask;
    r_len[{gi, 3'b0} +: 8]    = len;
    granted = 1'b0;
    for (int c = 0; c < 4 && !granted; c++) begin
      @(negedge clock);
      if (r_ready !== 4'b0000) granted = 1'b1;
      else begin @(posedge clock); #1; end
    end
    n_vec++;
    if (!granted || r_ready !== oh) begin
      n_bad++;
      $display("FAIL grant m_ready=%b required %b", r_ready, oh);
    end
    @(posedge clock); #1;
    r_valid[gi] = 1'b0;
    r_addr[{gi, 5'b0} +: 32]  = ~addr;
    r_wdata[{gi, 5'b0} +: 32] = ~data;
    r_mask[{gi, 1'b0} +: 2]   = ~mask;
    r_len[{gi, 3'b0} +: 8]    = ~len;
  endtask

  // Drive the slave side of the RR instance until m_done and report what
  // was observed; the calling test compares against the scoreboard.
  task automatic collect(input int rmode, input int rlast_at, input int wdelay, input bit err_in,
                         input logic [31:0] eaddr, input logic [31:0] ewdata,
                         output int g, output bit err, output int beats, output int cyc,
                         output bit stable, output bit rd_ok, output logic [3:0] bm,
                         output bit done);
    g = -1; err = 1'b0; beats = 0; cyc = -1; stable = 1'b1; rd_ok = 1'b1; bm = '0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      r_srready = (rmode == 0) ? 1'b1 : (c % 2 == 1);
      r_srlast  = (beats == rlast_at);
      r_swready = (c >= wdelay);
      r_serr    = err_in;
      r_srdata  = $urandom;
      @(negedge clock);
      if (r_srvalid && r_sraddr !== eaddr) stable = 1'b0;
      if (r_swvalid && (r_swaddr !== eaddr || r_swdata !== ewdata)) stable = 1'b0;
      if (r_rbeat !== 4'b0000) begin
        beats++;
        bm = bm | r_rbeat;
        if (r_rdata !== r_srdata) rd_ok = 1'b0;
      end
      if (r_done !== 4'b0000) begin
        done = 1'b1;
        cyc  = c;
        err  = r_err;
        case (r_done)
          4'b0001: g = 0;
          4'b0010: g = 1;
          4'b0100: g = 2;
          4'b1000: g = 3;
          default: g = 9;
        endcase
      end
      @(posedge clock); #1;
    end
    r_srready = 1'b0; r_srlast = 1'b0; r_swready = 1'b0; r_serr = 1'b0;
  endtask

  task automatic test_reset;
    r_valid = 4'hF; f_valid = 2'b11;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if (r_ready !== 4'b0 || f_ready !== 2'b0) begin
      n_bad++;
      $display("FAIL reset_ready rr=%b fp=%b required 0", r_ready, f_ready);
    end
    n_vec++;
    if ({r_rbeat, r_rdata, r_done, r_err, r_srvalid, r_swvalid, r_sraddr, r_swaddr,
         r_swdata, r_srlen, r_busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs nonzero srvalid=%b swvalid=%b busy=%b raddr=%h",
               r_srvalid, r_swvalid, r_busy, r_sraddr);
    end
    @(posedge clock); #1;
    r_valid = 4'h0; f_valid = 2'b00;
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({r_ready, r_done, r_srvalid, r_swvalid, r_busy, f_ready, f_busy} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset ready=%b busy=%b fp_busy=%b required 0", r_ready, r_busy, f_busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_fixed_priority;
    f_srready = 1'b1; f_len = '0; f_write = 2'b00;
    f_addr = {32'h0000_0200, 32'h0000_0100};
    f_valid = 2'b11;
    @(negedge clock);
    n_vec++;
    if (f_ready !== 2'b01 || f_srvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL fp_grant0 ready=%b srvalid=%b required 01/0", f_ready, f_srvalid);
    end
    @(posedge clock); #1;
    f_valid = 2'b10;
    @(negedge clock);
    n_vec++;
    if (f_srvalid !== 1'b1 || f_done !== 2'b01 || f_ready !== 2'b00 || f_sraddr !== 32'h100) begin
      n_bad++;
      $display("FAIL fp_done0 srvalid=%b done=%b ready=%b addr=%h required 1/01/00/100",
               f_srvalid, f_done, f_ready, f_sraddr);
    end
    @(posedge clock); #1;
    @(negedge clock);
    n_vec++;
    if (f_ready !== 2'b10 || f_srvalid !== 1'b0 || f_done !== 2'b00) begin
      n_bad++;
      $display("FAIL fp_grant1 ready=%b srvalid=%b done=%b required 10/0/00", f_ready, f_srvalid, f_done);
    end
    @(posedge clock); #1;
    f_valid = 2'b00;
    @(negedge clock);
    n_vec++;
    if (f_done !== 2'b10 || f_sraddr !== 32'h200) begin
      n_bad++;
      $display("FAIL fp_done1 done=%b addr=%h required 10/200", f_done, f_sraddr);
    end
    @(posedge clock); #1;
    f_srready = 1'b0;
  endtask

  task automatic test_round_robin;
    int gq[$];
    int e;
    logic [3:0] oh;
    gq = '{0, 1, 2, 3, 0};
    r_write = 4'h0; r_len = '0; r_srready = 1'b1;
    r_valid = 4'hF;
    for (int c = 0; c < 40 && gq.size() > 0; c++) begin
      @(negedge clock);
      if (r_ready !== 4'b0000) begin
        e  = gq.pop_front();
        oh = 4'b0001 << e;
        n_vec++;
        if (r_ready !== oh) begin
          n_bad++;
          $display("FAIL rr_order m_ready=%b required %b", r_ready, oh);
        end
      end
      @(posedge clock); #1;
    end
    r_valid = 4'h0;
    n_vec++;
    if (gq.size() != 0) begin
      n_bad++;
      $display("FAIL rr_timeout pending=%0d required 0", gq.size());
    end
    @(posedge clock); #1;
    r_srready = 1'b0;
  endtask

  task automatic test_read_burst;
    int g, beats, cyc; bit err, st, rok, dn; logic [3:0] bm; exp_t e;
    issue(2'd1, 1'b0, 32'h0000_1000, 32'h0, 2'b01, 1'b1, 8'd3);
    exp_q.push_back('{g: 1, err: 1'b0, beats: 4, cyc: 7});
    n_vec++;
    if (r_srlen !== 8'd3 || r_sburst !== 1'b1 || r_srmask !== 2'b01 || r_srsign !== 1'b1) begin
      n_bad++;
      $display("FAIL burst_fields rlen=%0d burst=%b rmask=%b rsign=%b required 3/1/01/1",
               r_srlen, r_sburst, r_srmask, r_srsign);
    end
    collect(1, -1, 0, 1'b0, 32'h0000_1000, 32'h0, g, err, beats, cyc, st, rok, bm, dn);
    e = exp_q.pop_front();
    n_vec++;
    if (!dn || g != e.g || beats != e.beats || cyc != e.cyc || err !== e.err) begin
      n_bad++;
      $display("FAIL burst4 got g=%0d beats=%0d cyc=%0d err=%b, want g=%0d beats=%0d cyc=%0d err=%b",
               g, beats, cyc, err, e.g, e.beats, e.cyc, e.err);
    end
    n_vec++;
    if (!st || !rok || bm !== 4'b0010) begin
      n_bad++;
      $display("FAIL burst4_data addr_stable=%b rdata_ok=%b rbeat_mask=%b required 1/1/0010", st, rok, bm);
    end
  endtask

  task automatic test_rlast;
    int g, beats, cyc; bit err, st, rok, dn; logic [3:0] bm; exp_t e;
    issue(2'd3, 1'b0, 32'h0000_2000, 32'h0, 2'b10, 1'b0, 8'd7);
    exp_q.push_back('{g: 3, err: 1'b0, beats: 3, cyc: 2});
    collect(0, 2, 0, 1'b0, 32'h0000_2000, 32'h0, g, err, beats, cyc, st, rok, bm, dn);
    e = exp_q.pop_front();
    n_vec++;
    if (!dn || g != e.g || beats != e.beats || cyc != e.cyc || !rok || bm !== 4'b1000) begin
      n_bad++;
      $display("FAIL rlast got g=%0d beats=%0d cyc=%0d rbeat_mask=%b, want g=%0d beats=%0d cyc=%0d",
               g, beats, cyc, bm, e.g, e.beats, e.cyc);
    end
  endtask

  task automatic test_write_err;
    int g, beats, cyc; bit err, st, rok, dn; logic [3:0] bm; exp_t e;
    issue(2'd0, 1'b1, 32'h0000_3000, 32'h1234_5678, 2'b00, 1'b0, 8'd0);
    exp_q.push_back('{g: 0, err: 1'b1, beats: 0, cyc: 0});
    collect(0, -1, 0, 1'b1, 32'h0000_3000, 32'h1234_5678, g, err, beats, cyc, st, rok, bm, dn);
    e = exp_q.pop_front();
    n_vec++;
    if (!dn || g != e.g || err !== e.err || beats != e.beats || cyc != e.cyc) begin
      n_bad++;
      $display("FAIL write_err got g=%0d err=%b beats=%0d cyc=%0d, want g=%0d err=%b beats=0 cyc=0",
               g, err, beats, cyc, e.g, e.err);
    end
    @(negedge clock);
    n_vec++;
    if (r_err !== 1'b0 || r_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL err_after_done m_err=%b busy=%b required 0/0", r_err, r_busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_write_delay;
    int g, beats, cyc; bit err, st, rok, dn; logic [3:0] bm; exp_t e;
    issue(2'd2, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 8'd0);
    exp_q.push_back('{g: 2, err: 1'b0, beats: 0, cyc: 5});
    n_vec++;
    if (r_swvalid !== 1'b1 || r_srvalid !== 1'b0 || r_swmask !== 2'b10) begin
      n_bad++;
      $display("FAIL wr_fields swvalid=%b srvalid=%b wmask=%b required 1/0/10", r_swvalid, r_srvalid, r_swmask);
    end
    collect(0, -1, 5, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, g, err, beats, cyc, st, rok, bm, dn);
    e = exp_q.pop_front();
    n_vec++;
    if (!dn || g != e.g || cyc != e.cyc || err !== e.err || !st) begin
      n_bad++;
      $display("FAIL write_delay got g=%0d cyc=%0d err=%b held=%b, want g=%0d cyc=%0d err=0 held=1",
               g, cyc, err, st, e.g, e.cyc);
    end
  endtask

  task automatic test_long_burst;
    int g, beats, cyc; bit err, st, rok, dn; logic [3:0] bm; exp_t e;
    issue(2'd1, 1'b0, 32'h0000_4000, 32'h0, 2'b10, 1'b0, 8'd255);
    exp_q.push_back('{g: 1, err: 1'b0, beats: 256, cyc: 255});
    collect(0, -1, 0, 1'b0, 32'h0000_4000, 32'h0, g, err, beats, cyc, st, rok, bm, dn);
    e = exp_q.pop_front();
    n_vec++;
    if (!dn || g != e.g || beats != e.beats || cyc != e.cyc || !st) begin
      n_bad++;
      $display("FAIL burst256 got g=%0d beats=%0d cyc=%0d, want g=%0d beats=%0d cyc=%0d",
               g, beats, cyc, e.g, e.beats, e.cyc);
    end
  endtask

  task automatic test_reset_mid_burst;
    issue(2'd2, 1'b0, 32'h0000_5000, 32'h0, 2'b10, 1'b0, 8'd7);
    r_srready = 1'b1;
    repeat (2) begin @(negedge clock); @(posedge clock); #1; end
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if ({r_ready, r_rbeat, r_rdata, r_done, r_err, r_srvalid, r_swvalid, r_sraddr, r_busy} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs done=%b rbeat=%b srvalid=%b busy=%b required 0",
               r_done, r_rbeat, r_srvalid, r_busy);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    n_vec++;
    if (r_srvalid !== 1'b0 || r_busy !== 1'b0 || r_done !== 4'b0) begin
      n_bad++;
      $display("FAIL midreset_abort srvalid=%b busy=%b done=%b required 0/0/0", r_srvalid, r_busy, r_done);
    end
    @(posedge clock); #1;
    r_len = '0; r_write = 4'h0; r_valid = 4'hF;
    @(negedge clock);
    n_vec++;
    if (r_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL midreset_ptr m_ready=%b required 0001", r_ready);
    end
    @(posedge clock); #1;
    r_valid = 4'h0;
    @(negedge clock);
    n_vec++;
    if (r_done !== 4'b0001) begin
      n_bad++;
      $display("FAIL midreset_next done=%b required 0001", r_done);
    end
    @(posedge clock); #1;
    r_srready = 1'b0;
  endtask

  initial begin
    f_valid = '0; f_write = '0; f_sign = '0; f_addr = '0; f_wdata = '0; f_mask = '0; f_len = '0;
    f_srready = 1'b0; f_srdata = 32'hA5A5_0001; f_srlast = 1'b0; f_swready = 1'b0; f_serr = 1'b0;
    r_valid = '0; r_write = '0; r_sign = '0; r_addr = '0; r_wdata = '0; r_mask = '0; r_len = '0;
    r_srready = 1'b0; r_srdata = '0; r_srlast = 1'b0; r_swready = 1'b0; r_serr = 1'b0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_read_burst();
    test_rlast();
    test_write_err();
    test_write_delay();
    test_long_burst();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, miscompares so far=%0d", n_bad);
    $fatal(1, "watchdog");
  end
endmodule
